// File: rtl/delay_line_if.sv
// delay_line_if: groups the delay line's sample, control and status signals.
// The master side drives the input sample and controls; the slave side (the
// delay line) returns the delayed sample and the primed status.
interface delay_line_if #(
  parameter int MAX_DELAY = 64,
  parameter int WIDTH     = 32
);
  localparam int DW = $clog2(MAX_DELAY) + 1;

  logic             enable;
  logic             flush;
  logic [DW-1:0]    delay;
  logic             validIn;
  logic [WIDTH-1:0] dataIn;
  logic             validOut;
  logic [WIDTH-1:0] dataOut;
  logic             primed;

  modport master (
    output enable, flush, delay, validIn, dataIn,
    input  validOut, dataOut, primed
  );

  modport slave (
    input  enable, flush, delay, validIn, dataIn,
    output validOut, dataOut, primed
  );
endinterface

// File: rtl/delay_line.sv
// delay_line: runtime-programmable delay of a data word and its valid flag by
// 1..MAX_DELAY enabled clocks. Data lives in an unreset RAM ring buffer; the
// per-entry valid flags are flops so a reset or flush masks stale RAM words.
// A change of the requested delay flushes the line automatically, and
// "primed" reports when the outputs carry post-flush samples.
module delay_line #(
  parameter int MAX_DELAY = 64,
  parameter int WIDTH     = 32
) (
  input  logic         clock,
  input  logic         reset,
  delay_line_if.slave  bus
);
  localparam int AW = $clog2(MAX_DELAY);
  localparam int DW = AW + 1;
  localparam logic [DW-1:0] D_ONE  = DW'(1);
  localparam logic [DW-1:0] D_MAX  = DW'(MAX_DELAY);
  localparam logic [DW-1:0] D_ZERO = DW'(0);
  localparam logic [AW-1:0] A_ONE  = AW'(1);

  // Architectural state
  logic [DW-1:0]        delay_q, delay_d;
  logic [AW-1:0]        wp_q, wp_d;
  logic [DW-1:0]        fill_q, fill_d;
  logic [MAX_DELAY-1:0] vbits_q, vbits_d;
  logic                 valid_out_q, valid_out_d;
  logic [WIDTH-1:0]     data_out_q, data_out_d;
  logic                 primed_q, primed_d;
  logic [WIDTH-1:0]     mem [MAX_DELAY];

  // Datapath helpers
  logic                 flush_s;
  logic                 mem_we_s;
  logic [AW-1:0]        rd_idx_s;

  // Clamp the requested delay into 1..MAX_DELAY.
  always_comb begin
    delay_d = bus.delay;
    if (bus.delay == D_ZERO) begin
      delay_d = D_ONE;
    end else if (bus.delay > D_MAX) begin
      delay_d = D_MAX;
    end else begin
      delay_d = bus.delay;
    end
  end

  // An explicit flush or any change of the effective delay clears the line;
  // the read tap sits delay_q-1 entries behind the write pointer (never on it).
  always_comb begin
    flush_s  = bus.flush | (delay_q != delay_d);
    rd_idx_s = wp_q - AW'(delay_q - D_ONE);
  end

  // Next-state logic: flush clears flags and status, an enabled edge shifts
  // the ring one entry, a disabled edge holds everything.
  always_comb begin
    wp_d        = wp_q;
    fill_d      = fill_q;
    vbits_d     = vbits_q;
    valid_out_d = valid_out_q;
    data_out_d  = data_out_q;
    primed_d    = primed_q;
    mem_we_s    = bus.enable;
    if (flush_s) begin
      // The sample on a flush edge is discarded: its flag stays cleared.
      vbits_d     = {MAX_DELAY{1'b0}};
      valid_out_d = 1'b0;
      fill_d      = D_ZERO;
      primed_d    = 1'b0;
      if (bus.enable) begin
        wp_d = wp_q + A_ONE;
      end else begin
        wp_d = wp_q;
      end
    end else if (bus.enable) begin
      vbits_d[wp_q] = bus.validIn;
      wp_d          = wp_q + A_ONE;
      if (fill_q == D_MAX) begin
        fill_d = fill_q;
      end else begin
        fill_d = fill_q + D_ONE;
      end
      if (delay_q == D_ONE) begin
        // Single-register behaviour: bypass the RAM.
        valid_out_d = bus.validIn;
        data_out_d  = bus.dataIn;
      end else begin
        valid_out_d = vbits_q[rd_idx_s];
        data_out_d  = mem[rd_idx_s];
      end
      primed_d = (fill_d >= delay_q);
    end else begin
      wp_d = wp_q;
    end
  end

  // Control and output registers, asynchronously cleared.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      delay_q     <= D_ONE;
      wp_q        <= {AW{1'b0}};
      fill_q      <= D_ZERO;
      vbits_q     <= {MAX_DELAY{1'b0}};
      valid_out_q <= 1'b0;
      data_out_q  <= {WIDTH{1'b0}};
      primed_q    <= 1'b0;
    end else begin
      delay_q     <= delay_d;
      wp_q        <= wp_d;
      fill_q      <= fill_d;
      vbits_q     <= vbits_d;
      valid_out_q <= valid_out_d;
      data_out_q  <= data_out_d;
      primed_q    <= primed_d;
    end
  end

  // Data RAM write port; contents are masked by the valid flags, so no reset.
  always_ff @(posedge clock) begin
    if (mem_we_s) begin
      mem[wp_q] <= bus.dataIn;
    end
  end

  assign bus.validOut = valid_out_q;
  assign bus.dataOut  = data_out_q;
  assign bus.primed   = primed_q;
endmodule

// File: doc/delay_line.md
# delay_line

Runtime-programmable, parametrised delay line for the sample pipeline. It delays a WIDTH-bit data word and its valid flag by 1..MAX_DELAY enabled clocks. Storage is a RAM ring buffer, so depth is not limited to 16 taps, and every valid flag clears on reset. It also provides clock-enable stall, synchronous flush, automatic flush on delay change, and a "primed" status, so it can replace fixed delay FIFOs wherever a trigger or capture path needs an adjustable pipeline offset.

## Interface
- MAX_DELAY, 64: largest delay in clocks; power of two, 2..256.
- WIDTH, 32: data width.
- DW (localparam), $clog2(MAX_DELAY)+1: width of the delay port.

Ports:
- clock  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high.
- enable  in  1  clock enable; low = whole line holds.
- flush  in  1  synchronous clear of all in-flight valid flags.
- delay  in  DW  requested delay. 0 is treated as 1; values above MAX_DELAY clamp to MAX_DELAY.
- validIn  in  1  input sample valid.
- dataIn  in  WIDTH  input sample.
- validOut  out  1  delayed valid (registered).
- dataOut  out  WIDTH  delayed data (registered).
- primed  out  1  line holds D post-flush samples, so outputs are meaningful.

## Operation
- Effective delay D = clamp(delay) is registered into delay_q every edge, independent of enable. delay_q resets to 1.
- Ring buffer: MAX_DELAY entries of data (RAM, no reset) plus a MAX_DELAY-bit valid array held in flops and cleared by reset.
- Write pointer wp has $clog2(MAX_DELAY) bits, wraps modulo MAX_DELAY, and resets to 0.
- Enabled edge without flush:
  - mem[wp] <= {validIn, dataIn}, then wp <= wp+1.
  - If delay_q==1, outputs <= {validIn, dataIn} (bypass).
  - Otherwise outputs <= mem[wp-(delay_q-1)], index modulo MAX_DELAY. That entry was written delay_q-1 enabled edges earlier; the index never equals wp.
- enable low: wp, mem, outputs and the fill counter all hold.
- Flush edge, when flush=1 or delay_q != clamp(delay); this applies regardless of enable:
  - All valid bits <= 0 and validOut <= 0.
  - fill <= 0 and primed <= 0.
  - The sample presented on that edge is discarded: its entry is written with valid=0, and wp advances only if enable=1.
  - dataOut is don't-care and need not be cleared.
- Fill counter:
  - Counts enabled non-flush edges and saturates at MAX_DELAY.
  - primed = (fill >= delay_q), registered. It asserts on the same edge that the first post-flush sample reaches the outputs.
- Data words emerging with valid=0 are don't-care. validOut is never 1 for a sample written before the last flush or reset.

## Timing
- Reset values: validOut=0, dataOut=0, primed=0, wp=0, fill=0, delay_q=1, all valid bits 0.
- Latency: a sample captured at enabled edge k appears on the outputs after enabled edge k+D-1.
  - D=1 behaves as a single register.
  - D=MAX_DELAY uses the full ring.
  - Disabled cycles stretch the latency in wall-clock terms but not in enabled edges.
- The first edge after reset with delay≠1 is a flush edge. This is legal and harmless.
- Delay change: the new value takes effect at the edge after delay changes. That edge flushes, and the line re-primes after D further enabled edges.
- Reset asserted mid-operation: outputs and valid flags clear immediately (asynchronously). RAM contents are stale but masked by the valid bits.
- Wrap-around: wp rolls over from MAX_DELAY-1 to 0 with no gap or duplicate in the output stream.

## Test plan
- Reset, then delay=1, then stream an incrementing count with validIn=1 -> dataOut equals the previous cycle's dataIn; primed=1 after the first enabled edge.
- MAX_DELAY=64, delay=64, stream of 200 words -> word n emerges after edge n+63; no error across three wp wraps; primed rises at edge 64.
- delay=5, toggle enable low for 3 cycles mid-stream -> outputs hold; ordering is preserved; latency is exactly 5 enabled edges.
- delay=8, pulse flush after 20 samples -> validOut=0 for the next 7 edges; the first valid output is the sample captured on the edge after the flush; primed is low for exactly that window.
- Change delay from 4 to 10 mid-stream -> auto-flush; no pre-change sample is ever output with validOut=1; new latency is 10.
- delay=0 and delay=200 (MAX_DELAY=64) -> they behave as 1 and 64 respectively; assert reset mid-stream -> validOut, dataOut and primed are 0 in the same cycle.
